// File: rtl/mpc_dense_pkg.sv
// Shared types and defaults for the dense MPC constraint checker.
// Holds the scan FSM state encoding and the default-width slack type.
package mpc_dense_pkg;

    localparam int unsigned N_CON_DEF = 12;
    localparam int unsigned W_DEF     = 21;
    localparam int          TOL_DEF   = 64;
    localparam int unsigned IDX_W     = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } state_e;

    // One guard bit over the h/gu word so h - gu never wraps.
    typedef logic signed [W_DEF:0] slack_t;

endpackage

// File: rtl/mpc_slack_min.sv
// Combinational running-minimum update for one slack sample.
// Only a strictly smaller slack replaces the minimum, so the earliest row wins ties.
module mpc_slack_min
    import mpc_dense_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic signed [W:0]       slack_i,
    input  logic [IDX_W-1:0]        idx_i,
    input  logic signed [W:0]       min_i,
    input  logic [IDX_W-1:0]        min_idx_i,
    output logic signed [W:0]       min_o,
    output logic [IDX_W-1:0]        min_idx_o
);

    always_comb begin
        min_o     = min_i;
        min_idx_o = min_idx_i;
        if (slack_i < min_i) begin
            min_o     = slack_i;
            min_idx_o = idx_i;
        end
    end

endmodule

// File: rtl/mpc_dense_constraint_check.sv
// Scans h and G*u row by row, reporting active set, violation count and minimum slack.
// Optional build macro MPC_CHECK_TOL_EN widens the active test to slack <= TOL.
module mpc_dense_constraint_check
    import mpc_dense_pkg::*;
#(
    parameter int unsigned N_CON = N_CON_DEF,
    parameter int unsigned W     = W_DEF,
    parameter int          TOL   = TOL_DEF
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    ap_start,
    output logic                    ap_done,
    output logic                    ap_idle,
    output logic                    ap_ready,
    output logic [IDX_W-1:0]        h_address0,
    output logic                    h_ce0,
    input  logic [W-1:0]            h_q0,
    output logic [IDX_W-1:0]        gu_address0,
    output logic                    gu_ce0,
    input  logic [W-1:0]            gu_q0,
    output logic [N_CON-1:0]        active_mask,
    output logic [3:0]              viol_cnt,
    output logic signed [W:0]       min_slack,
    output logic [IDX_W-1:0]        min_idx
);

    localparam logic signed [W:0] SlackMax = {1'b0, {W{1'b1}}};
    localparam logic [IDX_W-1:0]  LastRow  = IDX_W'(N_CON - 1);

`ifdef MPC_CHECK_TOL_EN
    localparam logic signed [W:0] ActThr = (W + 1)'(TOL);
`else
    localparam logic signed [W:0] ActThr = '0;
`endif

    state_e state_q, state_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic             rd_vld_q;
    logic [IDX_W-1:0] rd_idx_q;

    logic [N_CON-1:0]  mask_q, mask_d;
    logic [3:0]        viol_q, viol_d;
    logic signed [W:0] min_q, min_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic signed [W:0] slack;
    logic signed [W:0] min_new;
    logic [IDX_W-1:0]  idx_new;
    logic              start_acc;

    assign slack     = {h_q0[W-1], h_q0} - {gu_q0[W-1], gu_q0};
    assign start_acc = (state_q == StIdle) && ap_start;

    mpc_slack_min #(
        .W(W)
    ) u_slack_min (
        .slack_i   (slack),
        .idx_i     (rd_idx_q),
        .min_i     (min_q),
        .min_idx_i (idx_q),
        .min_o     (min_new),
        .min_idx_o (idx_new)
    );

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ap_start) state_d = StRead;
            StRead:  if (row_q == LastRow) state_d = StDrain;
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        h_ce0       = (state_q == StRead);
        gu_ce0      = (state_q == StRead);
        h_address0  = row_q;
        gu_address0 = row_q;
        ap_done     = (state_q == StDone);
        ap_ready    = (state_q == StDone);
        ap_idle     = (state_q == StIdle);
    end

    assign row_d = (state_q == StRead) ? row_q + 1'b1 : '0;

    // Results fold in one cycle after each address issue, when the read data lands.
    always_comb begin
        mask_d = mask_q;
        viol_d = viol_q;
        min_d  = min_q;
        idx_d  = idx_q;
        if (start_acc) begin
            mask_d = '0;
            viol_d = '0;
            min_d  = SlackMax;
            idx_d  = '0;
        end else if (rd_vld_q) begin
            mask_d[rd_idx_q] = (slack <= ActThr);
            viol_d           = viol_q + 4'(slack[W]);
            min_d            = min_new;
            idx_d            = idx_new;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            row_q    <= '0;
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
            mask_q   <= '0;
            viol_q   <= '0;
            min_q    <= '0;
            idx_q    <= '0;
        end else begin
            row_q    <= row_d;
            rd_vld_q <= (state_q == StRead);
            rd_idx_q <= row_q;
            mask_q   <= mask_d;
            viol_q   <= viol_d;
            min_q    <= min_d;
            idx_q    <= idx_d;
        end
    end

    assign active_mask = mask_q;
    assign viol_cnt    = viol_q;
    assign min_slack   = min_q;
    assign min_idx     = idx_q;

endmodule

// File: doc/mpc_dense_constraint_check.md
MPC_DENSE_CONSTRAINT_CHECK -- requirements
Module: mpc_dense_constraint_check

Interface
REQ-001 SHALL have parameter N_CON, default 12, meaning number of constraint rows in h/gu.
REQ-002 SHALL have parameter W, default 21, meaning signed fixed-point word width of h and gu entries.
REQ-003 SHALL have parameter TOL, default 64, meaning signed active-set tolerance in LSBs (used only under MPC_CHECK_TOL_EN).
REQ-004 SHALL have port ap_clk  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port ap_rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports ap_start in 1, ap_done out 1, ap_idle out 1, ap_ready out 1: block-level start/done handshake.
REQ-007 SHALL have ports h_address0 out 4, h_ce0 out 1, h_q0 in W: read port of constraint RHS vector h (1-cycle read latency).
REQ-008 SHALL have ports gu_address0 out 4, gu_ce0 out 1, gu_q0 in W: read port of product G*u (1-cycle read latency).
REQ-009 SHALL have ports active_mask out N_CON (bit i = row i active), viol_cnt out 4 (rows with slack < 0), min_slack out W+1 signed, min_idx out 4.

Function
REQ-010 SHALL compute per row slack[i] = h[i] - gu[i] at W+1 bits, sign-extended, no wrap or saturation.
REQ-011 SHALL implement FSM IDLE -> READ (ap_start=1) -> DRAIN (after row N_CON-1 issued) -> DONE -> IDLE, one cycle in DRAIN and DONE.
REQ-012 SHALL in READ issue address i (0..N_CON-1) on both h_address0 and gu_address0 with h_ce0=gu_ce0=1, one row per cycle; ce low in all other states.
REQ-013 SHALL consume h_q0/gu_q0 in the cycle after each address issue (READ cycles 2..N_CON and DRAIN).
REQ-014 SHALL assert ap_done and ap_ready together for exactly the one DONE cycle, i.e. N_CON+2 cycles after ap_start sampled high in IDLE (14 for default).
REQ-015 SHALL drive ap_idle=1 only in IDLE.
REQ-016 SHALL ignore ap_start outside IDLE; ap_start high in DONE is not accepted until the next IDLE cycle.
REQ-017 SHALL clear active_mask, viol_cnt and set min_slack to the most-positive W+1 value, min_idx=0 on entering READ.
REQ-018 SHALL update min_slack/min_idx only on strictly smaller slack, so the lowest index wins ties.
REQ-019 SHALL hold all result outputs stable from DONE until the next accepted ap_start.
REQ-020 SHALL count slack == 0 as active but not as violation.

Reset
REQ-021 SHALL on ap_rst_n low, asynchronously, force FSM to IDLE, row counter 0, ap_done=ap_ready=0, ap_idle=1, ce outputs 0, active_mask=0, viol_cnt=0, min_slack=0, min_idx=0.
REQ-022 SHALL abandon any in-flight scan on reset mid-operation with no ap_done; a fresh ap_start restarts from row 0.

Configuration
REQ-023 SHALL with MPC_CHECK_TOL_EN defined mark row active when slack <= TOL.
REQ-024 SHALL with MPC_CHECK_TOL_EN undefined mark row active when slack <= 0, TOL unused; viol_cnt, min_slack identical in both builds.

Structure
REQ-025 SHALL take N_CON, W defaults, FSM state enum and slack typedef from shared package mpc_dense_pkg.
REQ-026 SHALL contain one sub-module mpc_slack_min (combinational compare of slack vs running min, returns new min/idx).

Verification
REQ-027 SHALL cover: h[i]=1000, gu[i]=0 all rows -> active_mask=0, viol_cnt=0, min_slack=1000, min_idx=0, ap_done at cycle 14.
REQ-028 SHALL cover: h=0, gu[3]=5, gu[7]=9, rest 0 -> viol_cnt=2, min_slack=-9, min_idx=7, active_mask=0xFFF.
REQ-029 SHALL cover: extremes h[0]=-1048576, gu[0]=1048575 -> min_slack=-2097151, min_idx=0 with no wrap.
REQ-030 SHALL cover: slack[i]=32 all rows -> active_mask=0xFFF with MPC_CHECK_TOL_EN, 0x000 without.
REQ-031 SHALL cover: ap_rst_n low at cycle 6 of scan -> outputs reset values, no ap_done; restart yields correct result at 14 cycles.
REQ-032 SHALL cover: ap_start held high continuously -> back-to-back scans, ap_done every 15 cycles, ce pulses only in READ.
